edge_event_unit: RTL and testbench
==================================

EDGE_EVENT_UNIT -- requirements
Module: edge_event_unit

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per channel, legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a new level must hold before acceptance, minimum 1.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port signal_in, input, N_CH: raw asynchronous inputs (buttons, mouse keys).
REQ-007 SHALL have port mode, input, 2*N_CH: per-channel mode at bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 both.
REQ-008 SHALL have port clear, input, N_CH: per-channel clear of the pending flag.
REQ-009 SHALL have port pulse, output, N_CH: one-cycle registered event strobe.
REQ-010 SHALL have port pending, output, N_CH: sticky event flag.
REQ-011 SHALL have port level, output, N_CH: filtered, synchronised input level.

Function
REQ-012 SHALL pass each signal_in bit through a SYNC_STAGES-deep flop chain before any other use.
REQ-013 SHALL keep one debounce counter per channel, width $clog2(DEBOUNCE_CYCLES+1), cleared whenever the synchroniser output equals level.
REQ-014 SHALL increment the counter on each cycle the synchroniser output differs from level, and toggle level on the edge where the difference has held for DEBOUNCE_CYCLES consecutive cycles; the counter clears on that same edge.
REQ-015 SHALL reject any synchronised excursion shorter than DEBOUNCE_CYCLES cycles, with no level change and no pulse.
REQ-016 SHALL make level follow a stable raw change SYNC_STAGES+DEBOUNCE_CYCLES cycles after the raw change is first sampled.
REQ-017 SHALL assert pulse[i] high for exactly one cycle, on the cycle after level[i] changes, when the change direction matches mode[i].
REQ-018 SHALL never assert pulse[i] while mode[i]=00; level[i] and debounce SHALL keep operating regardless of mode.
REQ-019 SHALL sample mode in the same cycle the pulse is generated; a mode change SHALL affect only pulses generated on later edges.
REQ-020 SHALL set pending[i] on the edge that asserts pulse[i], and clear it on an edge where clear[i]=1 and no new event occurs.
REQ-021 SHALL give set priority over clear when pulse[i] is generated and clear[i]=1 on the same edge, so pending[i] stays 1.
REQ-022 SHALL keep channels fully independent; simultaneous events on any channels SHALL all be reported in the same cycle.

Reset
REQ-023 SHALL, while rst=1, asynchronously force all synchroniser flops, counters, level, pulse and pending to 0.
REQ-024 SHALL treat the post-reset level as low, so an input held high through reset SHALL produce a rising event SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after reset release, given mode 01 or 11.
REQ-025 SHALL abandon any in-progress debounce count when reset is asserted, with no partial event after release.

Configuration
REQ-026 SHALL compile the debounce filter in only when macro EDGE_EVENT_DEBOUNCE_EN is defined.
REQ-027 SHALL, without EDGE_EVENT_DEBOUNCE_EN, drive level directly from the synchroniser output (latency SYNC_STAGES), implement no counters and ignore DEBOUNCE_CYCLES; pulse and pending rules are unchanged.

Verification (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-028 SHALL cover: mode[1:0]=01, signal_in[0] 0->1 held -> level[0]=1 after 6 cycles, pulse[0]=1 for one cycle at cycle 7, pending[0]=1 thereafter.
REQ-029 SHALL cover: signal_in[1] high for 3 cycles then low -> level[1], pulse[1] and pending[1] remain 0.
REQ-030 SHALL cover: mode[5:4]=11, signal_in[2] pulsed high for 10 cycles -> two single-cycle pulses on pulse[2], 10 cycles apart.
REQ-031 SHALL cover: clear[0]=1 on the same edge a new pulse[0] is generated -> pending[0] stays 1; clear[0]=1 on the next cycle alone -> pending[0]=0.
REQ-032 SHALL cover: rst asserted 2 cycles into a debounce count -> all outputs 0 immediately without a clock edge; no pulse after release if input has returned low.
REQ-033 SHALL cover, with the macro undefined: a 1-cycle high on signal_in[3] with mode[7:6]=01 -> level[3] high for 1 cycle after 2 cycles, one pulse[3].

Source files
------------

// File: rtl/edge_event_unit.sv
// rtl/edge_event_unit.sv - per-channel synchroniser, optional debounce, edge pulse and sticky pending flag
// Debounce filter is built only when EDGE_EVENT_DEBOUNCE_EN is defined; otherwise level is the synchroniser output.
module edge_event_unit #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   signal_in,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clear,
  output logic [N_CH-1:0]   pulse,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   level
);

  if (N_CH < 1 || N_CH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("edge_event_unit: illegal parameter value");
  end

  logic [N_CH-1:0] sync_out;
  logic [N_CH-1:0] level_d;
  logic [N_CH-1:0] event_now;

`ifdef EDGE_EVENT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in[i]};
    end

    assign sync_out[i] = sync_q[SYNC_STAGES-1];

`ifdef EDGE_EVENT_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    // Level toggles on the edge that would be the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_out[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign level[i] = lvl;
`else
    assign level[i] = sync_out[i];
`endif
  end

  // level_d holds last cycle's level, so a change is seen (and mode sampled) one cycle after it happens.
  always_comb begin
    event_now = '0;
    for (int i = 0; i < N_CH; i++) begin
      event_now[i] = (level[i] & ~level_d[i] & mode[2*i]) |
                     (~level[i] & level_d[i] & mode[2*i+1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= '0;
      pulse   <= '0;
      pending <= '0;
    end else begin
      level_d <= level;
      pulse   <= event_now;
      pending <= event_now | (pending & ~clear);
    end
  end

endmodule

// File: tb/tb_edge_event_unit.sv
// tb/tb_edge_event_unit.sv - self-checking bench for edge_event_unit
// Expected latency follows EDGE_EVENT_DEBOUNCE_EN as seen by this compilation.
module tb_edge_event_unit;
  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;
`ifdef EDGE_EVENT_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = S + D;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = S;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   signal_in;
  logic [2*N-1:0] mode;
  logic [N-1:0]   clear;
  logic [N-1:0]   pulse;
  logic [N-1:0]   pending;
  logic [N-1:0]   level;

  always #5 clk = ~clk;

  edge_event_unit #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .clear(clear),
    .pulse(pulse), .pending(pending), .level(level)
  );

  int checks = 0;
  int errors = 0;

  // Reference: raw input delayed S edges, level flips once the last D synchronised samples all disagree with it.
  logic [N-1:0] m_pipe [S];
  logic [N-1:0] m_hist [$];
  logic [N-1:0] m_level, m_level_prev, m_pulse, m_pending;

  function automatic void model_reset();
    for (int k = 0; k < S; k++) m_pipe[k] = '0;
    m_hist.delete();
    for (int k = 0; k < D; k++) m_hist.push_back('0);
    m_level = '0; m_level_prev = '0; m_pulse = '0; m_pending = '0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] sig, input logic [2*N-1:0] md,
                                     input logic [N-1:0] clr);
    logic [N-1:0] ev, nl, so, h;
    bit all_diff;
    for (int c = 0; c < N; c++)
      ev[c] = (m_level[c] & ~m_level_prev[c] & md[2*c]) | (~m_level[c] & m_level_prev[c] & md[2*c+1]);
    m_pending    = ev | (m_pending & ~clr);
    m_pulse      = ev;
    m_level_prev = m_level;
    for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = sig;
    so = m_pipe[S-1];
    if (DEB) begin
      nl = m_level;
      for (int c = 0; c < N; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) begin
          h = m_hist[m_hist.size()-1-k];
          if (h[c] == m_level[c]) all_diff = 1'b0;
        end
        if (all_diff) nl[c] = ~m_level[c];
      end
      m_level = nl;
      m_hist.push_back(so);
      void'(m_hist.pop_front());
    end else begin
      m_level = so;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] sig, input logic [2*N-1:0] md, input logic [N-1:0] clr);
    signal_in = sig; mode = md; clear = clr;
    @(posedge clk);
    model_edge(sig, md, clr);
    #1;
    check("model pulse", pulse, m_pulse);
    check("model pending", pending, m_pending);
    check("model level", level, m_level);
  endtask

  // Called just after a clock edge; checks the asynchronous clear before any further edge.
  task automatic do_reset(input logic [N-1:0] sig);
    signal_in = sig;
    rst = 1'b1;
    model_reset();
    #2;
    check("async rst pulse", pulse, 0);
    check("async rst pending", pending, 0);
    check("async rst level", level, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]   sig;
    logic [2*N-1:0] md;
    logic [N-1:0]   clr;
    logic           lvl;
    logic           pls;
    logic           pnd;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int cnt, seen, first, second, idx;
    logic [N-1:0] r_sig, r_clr;
    logic [2*N-1:0] r_md;

    for (int k = 0; k < 12; k++) begin
      tbl[k].sig = 4'b0001;
      tbl[k].md  = 8'b0000_0001;
      tbl[k].clr = 4'b0000;
      tbl[k].lvl = (k + 1 >= LAT);
      tbl[k].pls = (k + 1 == LAT + 1);
      tbl[k].pnd = (k + 1 >= LAT + 1);
    end

    rst = 1'b1; signal_in = '0; mode = '0; clear = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset pulse", pulse, 0);
    check("reset pending", pending, 0);
    check("reset level", level, 0);
    rst = 1'b0;

    // rising edge on ch0
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].sig, tbl[k].md, tbl[k].clr);
      check("tbl level0", level[0], tbl[k].lvl);
      check("tbl pulse0", pulse[0], tbl[k].pls);
      check("tbl pending0", pending[0], tbl[k].pnd);
    end

    // short excursion on ch1
    cnt = 0; seen = 0;
    for (int k = 0; k < 13; k++) begin
      step((k < 3) ? 4'b0011 : 4'b0001, 8'b0000_1101, 4'b0000);
      cnt += pulse[1]; seen |= level[1];
    end
    check("short ch1 pulses", cnt, DEB ? 0 : 2);
    check("short ch1 level seen", seen, DEB ? 0 : 1);
    check("short ch1 pending", pending[1], DEB ? 0 : 1);

    // ch2 both edges, 10-cycle high
    first = -1; second = -1; cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step((k < 10) ? 4'b0101 : 4'b0001, 8'b0011_0001, 4'b0000);
      if (pulse[2]) begin
        cnt++;
        if (first < 0) first = k; else if (second < 0) second = k;
      end
    end
    check("both-edge pulse count", cnt, 2);
    check("both-edge spacing", second - first, 10);

    // set wins over clear on the same edge
    step(4'b0001, 8'b0011_0011, 4'b0001);
    check("clear ch0 pending", pending[0], 0);
    for (int k = 0; k < LAT; k++) step(4'b0000, 8'b0011_0011, 4'b0000);
    step(4'b0000, 8'b0011_0011, 4'b0001);
    check("set-over-clear pulse0", pulse[0], 1);
    check("set-over-clear pending0", pending[0], 1);
    step(4'b0000, 8'b0011_0011, 4'b0001);
    check("clear alone pending0", pending[0], 0);
    check("clear alone pulse0", pulse[0], 0);

    // reset mid-debounce, input low afterwards
    for (int k = 0; k < S + 2; k++) step(4'b0001, 8'b0011_0011, 4'b0000);
    check("pre-reset pending2", pending[2], 1);
    do_reset(4'b0000);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step(4'b0000, 8'b1111_1111, 4'b0000);
      cnt += $countones(pulse);
    end
    check("no pulse after reset", cnt, 0);

    // input high through reset gives a rising event
    do_reset(4'b0001);
    idx = -1;
    for (int k = 1; k <= 20; k++) begin
      step(4'b0001, 8'b0000_0001, 4'b0000);
      if (pulse[0] && idx < 0) idx = k;
    end
    check("post-reset rise edge", idx, LAT + 1);

    // single-cycle blip on ch3
    cnt = 0; seen = 0;
    for (int k = 0; k < 13; k++) begin
      step((k == 0) ? 4'b1001 : 4'b0001, 8'b0100_0001, 4'b0000);
      cnt += pulse[3]; seen += level[3];
    end
    check("blip ch3 pulses", cnt, DEB ? 0 : 1);
    check("blip ch3 level cycles", seen, DEB ? 0 : 1);

    // randomized run against the model
    r_sig = '0; r_md = 8'hE4;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(7) == 0) r_sig[c] = ~r_sig[c];
        r_clr[c] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(49) == 0) r_md = 8'($urandom);
      if (t == 1500) do_reset(r_sig);
      step(r_sig, r_md, r_clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
